// File: rtl/sar_search_pkg.sv
// Shared definitions for comparator-driven search controllers.
package sar_search_pkg;

  // Controller phases: idle, one trial per cycle, one-cycle completion.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StTest = 2'd1,
    StDone = 2'd2
  } state_e;

  // True when exactly one of the three comparator flags is set.
  function automatic logic one_hot3(input logic lt, input logic eq, input logic gt);
    return (lt & ~eq & ~gt) | (~lt & eq & ~gt) | (~lt & ~eq & gt);
  endfunction

endpackage

// File: rtl/sar_search_if.sv
// Handshake and comparator-loop signals between a search controller and its user.
interface sar_search_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] trial;
  logic             cmp_lt;
  logic             cmp_eq;
  logic             cmp_gt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             found;
  logic             err;

  // Controller side.
  modport slave (
    input  start, cmp_lt, cmp_eq, cmp_gt,
    output trial, busy, done, result, found, err
  );

  // User / comparator side.
  modport master (
    output start, cmp_lt, cmp_eq, cmp_gt,
    input  trial, busy, done, result, found, err
  );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search: drives trial values into an external comparator and
// resolves one bit per clock from the MSB down, stopping early on an exact match.
module sar_search
  import sar_search_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  sar_search_if.slave bus
);

  localparam int unsigned IdxW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             found_q, found_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] bit_k;
  logic [WIDTH-1:0] acc_upd;

  // Bit under test and the accumulator after this cycle's gt/lt decision.
  always_comb begin
    bit_k   = WIDTH'(1) << idx_q;
    acc_upd = bus.cmp_gt ? (acc_q | bit_k) : (acc_q & ~bit_k);
  end

  // Next-state and datapath updates for the search FSM.
  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    acc_d    = acc_q;
    result_d = result_q;
    idx_d    = idx_q;
    found_d  = found_q;
    err_d    = err_q;

    unique case (state_q)
      StIdle: begin
        trial_d = '0;
        if (bus.start) begin
          acc_d    = '0;
          found_d  = 1'b0;
          err_d    = 1'b0;
          result_d = '0;
          idx_d    = IdxW'(WIDTH - 1);
          trial_d  = WIDTH'(1) << (WIDTH - 1);
          state_d  = StTest;
        end
      end
      StTest: begin
        if (!one_hot3(bus.cmp_lt, bus.cmp_eq, bus.cmp_gt)) begin
          err_d    = 1'b1;
          found_d  = 1'b0;
          result_d = '0;
          trial_d  = '0;
          state_d  = StDone;
        end else if (bus.cmp_eq) begin
          found_d  = 1'b1;
          result_d = trial_q;
          trial_d  = '0;
          state_d  = StDone;
        end else begin
          acc_d = acc_upd;
          if (idx_q == '0) begin
            result_d = acc_upd;
            found_d  = 1'b0;
            trial_d  = '0;
            state_d  = StDone;
          end else begin
            idx_d   = idx_q - IdxW'(1);
            // 1 << (k-1) is the current bit shifted down; avoids a second decoder.
            trial_d = acc_upd | (bit_k >> 1);
          end
        end
      end
      StDone: begin
        trial_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any search immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      trial_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      idx_q    <= IdxW'(WIDTH - 1);
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  assign bus.trial  = trial_q;
  assign bus.busy   = (state_q == StTest);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;
  assign bus.found  = found_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: closes the loop through a behavioural magnitude comparator.
module tb_sar_search;
  localparam int unsigned WIDTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sar_search_if #(.WIDTH(WIDTH)) bus ();

  logic [WIDTH-1:0] target = '0;
  logic             bad = 1'b0;

  // Magnitude comparator: a = target, b = trial; 'bad' forces lt and gt together.
  assign bus.cmp_lt = bad | (target < bus.trial);
  assign bus.cmp_gt = bad | (target > bus.trial);
  assign bus.cmp_eq = ~bad & (target == bus.trial);

  sar_search #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int n_bad = 0;
  int trial_log[$];
  int model_log[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Binary search over [0, 2^WIDTH): each step tries the lower bound plus half the span.
  function automatic void model_trials(input int t);
    int lo;
    int span;
    model_log.delete();
    lo   = 0;
    span = 1 << WIDTH;
    while (span > 1) begin
      span = span / 2;
      model_log.push_back(lo + span);
      if (lo + span == t) break;
      if (t > lo + span) lo = lo + span;
    end
  endfunction

  // Samples needed: an eq lands once every bit above the lowest set bit is resolved.
  function automatic int model_edges(input int t);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (((t >> i) & 1) == 1) return int'(WIDTH) - i;
    end
    return int'(WIDTH);
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
  task automatic run_search(input int tgt, input bit hold, input int bad_at,
                            output int r, output int f, output int e, output int edges);
    bit ok;
    trial_log.delete();
    target    = tgt[WIDTH-1:0];
    bad       = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    check("busy_after_start", int'(bus.busy), 1);
    if (!hold) bus.start = 1'b0;
    edges = 0;
    ok    = 1'b0;
    for (int c = 0; c < 4 * int'(WIDTH); c++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy) begin
        trial_log.push_back(int'(bus.trial));
        edges++;
        if (edges == bad_at) bad = 1'b1;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    bad       = 1'b0;
    check("done_seen", int'(ok), 1);
    check("done_busy_low", int'(bus.busy), 0);
    check("done_trial_zero", int'(bus.trial), 0);
    r = int'(bus.result);
    f = int'(bus.found);
    e = int'(bus.err);
    @(negedge clk);
    check("done_one_cycle", int'(bus.done), 0);
    check("result_held", int'(bus.result), r);
    check("found_held", int'(bus.found), f);
  endtask

  task automatic check_trials(input string name);
    check({name, "_ntrials"}, trial_log.size(), model_log.size());
    if (trial_log.size() == model_log.size()) begin
      foreach (model_log[i]) check({name, "_trial"}, trial_log[i], model_log[i]);
    end
  endtask

  typedef struct {
    int tgt;
    int bad_at;
    int exp_r;
    int exp_f;
    int exp_e;
    int exp_edges;
  } vec_t;

  initial begin
    vec_t vecs[$];
    int r, f, e, edges, t;
    int exp_seq[$];

    bus.start = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_trial", int'(bus.trial), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_result", int'(bus.result), 0);
    check("rst_found", int'(bus.found), 0);
    check("rst_err", int'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    vecs.push_back('{tgt: 5,  bad_at: 0, exp_r: 5,  exp_f: 1, exp_e: 0, exp_edges: 4});
    vecs.push_back('{tgt: 0,  bad_at: 0, exp_r: 0,  exp_f: 0, exp_e: 0, exp_edges: 4});
    vecs.push_back('{tgt: 8,  bad_at: 0, exp_r: 8,  exp_f: 1, exp_e: 0, exp_edges: 1});
    vecs.push_back('{tgt: 5,  bad_at: 2, exp_r: 0,  exp_f: 0, exp_e: 1, exp_edges: 2});
    vecs.push_back('{tgt: 13, bad_at: 0, exp_r: 13, exp_f: 1, exp_e: 0, exp_edges: 4});
    vecs.push_back('{tgt: 12, bad_at: 0, exp_r: 12, exp_f: 1, exp_e: 0, exp_edges: 2});
    vecs.push_back('{tgt: 4,  bad_at: 0, exp_r: 4,  exp_f: 1, exp_e: 0, exp_edges: 2});
    vecs.push_back('{tgt: 15, bad_at: 0, exp_r: 15, exp_f: 1, exp_e: 0, exp_edges: 4});

    foreach (vecs[i]) begin
      run_search(vecs[i].tgt, 1'b0, vecs[i].bad_at, r, f, e, edges);
      check("vec_result", r, vecs[i].exp_r);
      check("vec_found", f, vecs[i].exp_f);
      check("vec_err", e, vecs[i].exp_e);
      check("vec_edges", edges, vecs[i].exp_edges);
    end

    // Hand-written trial sequences.
    run_search(5, 1'b0, 0, r, f, e, edges);
    exp_seq = '{8, 4, 6, 5};
    model_log = exp_seq;
    check_trials("t5");
    run_search(0, 1'b0, 0, r, f, e, edges);
    exp_seq = '{8, 4, 2, 1};
    model_log = exp_seq;
    check_trials("t0");

    // Back-to-back sweep with start held high through busy and done.
    for (int k = 0; k < (1 << WIDTH); k++) begin
      run_search(k, 1'b1, 0, r, f, e, edges);
      model_trials(k);
      check("sweep_result", r, k);
      check("sweep_found", f, int'(k != 0));
      check("sweep_err", e, 0);
      check("sweep_edges", edges, model_edges(k));
      check_trials("sweep");
    end

    // Randomized targets.
    for (int k = 0; k < 24; k++) begin
      t = int'($urandom_range((1 << WIDTH) - 1, 0));
      run_search(t, 1'($urandom_range(1, 0)), 0, r, f, e, edges);
      model_trials(t);
      check("rand_result", r, t);
      check("rand_found", f, int'(t != 0));
      check("rand_err", e, 0);
      check("rand_edges", edges, model_edges(t));
      check_trials("rand");
    end

    // Asynchronous reset mid-search, after the second sample edge.
    target    = 4'd5;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", int'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_trial", int'(bus.trial), 0);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_done", int'(bus.done), 0);
    check("arst_result", int'(bus.result), 0);
    check("arst_found", int'(bus.found), 0);
    check("arst_err", int'(bus.err), 0);
    @(posedge clk);
    #1;
    check("arst_no_done", int'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_done", int'(bus.done), 0);
    run_search(13, 1'b0, 0, r, f, e, edges);
    check("post_rst_result", r, 13);
    check("post_rst_found", f, 1);

    $display("test done: total=%0d bad=%0d", total, n_bad);
    $finish;
  end

endmodule
